// File: rtl/hilo_pkg.sv
// Shared op codes and pipe-stage payload for the HI/LO accumulate unit.
package hilo_pkg;

  // Payload width of a pipe stage; the unit's DATA_W must not exceed this.
  localparam int unsigned HILO_DATA_W = 32;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MTHI = 3'd1;
  localparam logic [2:0] OP_MTLO = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_MADD = 3'd4;
  localparam logic [2:0] OP_MSUB = 3'd5;

  typedef struct packed {
    logic                   valid;
    logic [2:0]             code;
    logic [HILO_DATA_W-1:0] hi;
    logic [HILO_DATA_W-1:0] lo;
  } hilo_op_t;

endpackage

// File: rtl/hilo_delay_pipe.sv
// LATENCY-deep shift register carrying accepted HI/LO ops to their commit stage.
module hilo_delay_pipe
  import hilo_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic     Clk,
  input  logic     Rst,
  input  hilo_op_t in_op,
  output hilo_op_t out_op,
  output logic     commit_now
);

  hilo_op_t stage [1:LATENCY];

  // Reset empties every stage so flushed ops can never reach commit.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int unsigned i = 1; i <= LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[1] <= in_op;
      for (int unsigned i = 2; i <= LATENCY; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_op     = stage[LATENCY];
  assign commit_now = stage[LATENCY].valid;

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO result unit with fixed-latency in-order commit and MFHI/MFLO stall.
// Define HILO_FWD_EN to bypass the committing value onto rd_hi/rd_lo.
module hilo_acc_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LATENCY   = 3,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [DATA_W-1:0] op_hi,
  input  logic [DATA_W-1:0] op_lo,
  input  logic              rd_req,
  output logic              rd_stall,
  output logic [DATA_W-1:0] rd_hi,
  output logic [DATA_W-1:0] rd_lo,
  output logic              busy,
  output logic [DATA_W-1:0] HI_out,
  output logic [DATA_W-1:0] LO_out,
  output logic [DATA_W-1:0] debug_HI,
  output logic [DATA_W-1:0] debug_LO
);

  localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);
  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [CNT_W-1:0]  outst;
  logic [DATA_W-1:0] hi_q, lo_q, next_hi, next_lo;
  logic [PROD_W-1:0] acc, opnd;
  hilo_op_t          issue_op, commit_op;
  logic              commit_now, commit, accept;

  assign op_ready = (outst < CNT_W'(MAX_OUTST));
  assign accept   = op_valid && op_ready;
  assign busy     = (outst != '0);
  assign commit   = commit_now && commit_op.valid;

  always_comb begin
    issue_op       = '0;
    issue_op.valid = accept;
    issue_op.code  = op_code;
    issue_op.hi    = HILO_DATA_W'(op_hi);
    issue_op.lo    = HILO_DATA_W'(op_lo);
  end

  hilo_delay_pipe #(.LATENCY(LATENCY)) u_pipe (
    .Clk        (Clk),
    .Rst        (Rst),
    .in_op      (issue_op),
    .out_op     (commit_op),
    .commit_now (commit_now)
  );

  // Commit ALU reads the architectural pair so back-to-back accumulates chain.
  always_comb begin
    acc     = {hi_q, lo_q};
    opnd    = {DATA_W'(commit_op.hi), DATA_W'(commit_op.lo)};
    next_hi = hi_q;
    next_lo = lo_q;
    if (commit) begin
      case (commit_op.code)
        OP_MTHI: next_hi = DATA_W'(commit_op.lo);
        OP_MTLO: next_lo = DATA_W'(commit_op.lo);
        OP_WR:   {next_hi, next_lo} = opnd;
        OP_MADD: {next_hi, next_lo} = acc + opnd;
        OP_MSUB: {next_hi, next_lo} = acc - opnd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      hi_q <= next_hi;
      lo_q <= next_lo;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      outst <= '0;
    end else begin
      case ({accept, commit})
        2'b10:   outst <= outst + CNT_W'(1);
        2'b01:   outst <= outst - CNT_W'(1);
        default: ;
      endcase
    end
  end

`ifdef HILO_FWD_EN
  assign rd_stall = rd_req && ((outst > CNT_W'(1)) || ((outst == CNT_W'(1)) && !commit));
  assign rd_hi    = next_hi;
  assign rd_lo    = next_lo;
`else
  assign rd_stall = rd_req && busy;
  assign rd_hi    = hi_q;
  assign rd_lo    = lo_q;
`endif

  assign HI_out   = hi_q;
  assign LO_out   = lo_q;
  assign debug_HI = hi_q;
  assign debug_LO = lo_q;

endmodule
